// File: rtl/perceptron_pkg.sv
// Shared types, defaults and width helpers for the perceptron scheduler.
package perceptron_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   localparam logic [1:0] CLS_CROSS  = 2'b10;
   localparam logic [1:0] CLS_CIRCLE = 2'b01;
   localparam logic [1:0] CLS_NONE   = 2'b00;

   localparam int unsigned DEF_TH_CROSS  = 11;
   localparam int unsigned DEF_TH_CIRCLE = 4;

   function automatic int unsigned acc_width(input int unsigned width);
      return $clog2(3 * width + 1);
   endfunction

   // Corner pixels weigh 2, the centre pixel weighs 3.
   function automatic logic [1:0] def_weight(input int unsigned i);
      case (i)
         12:            return 2'd3;
         0, 4, 20, 24:  return 2'd2;
         default:       return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first valid request at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   int unsigned best_d;
   int unsigned d;
   logic        found;

   // Pick the requester with the smallest circular distance from ptr.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      found  = 1'b0;
      best_d = N;
      d      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         d = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + N - 32'(ptr));
         if (en && req[i] && (d < best_d)) begin
            best_d = d;
            found  = 1'b1;
            idx    = IW'(i);
         end
      end
      if (found) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/perceptron_sched.sv
// Round-robin frame scheduler, bit-serial weight accumulator and config registers
// for the 5x5 perceptron classifier.
module perceptron_sched
   import perceptron_pkg::*;
#(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned NREQ  = 2,
   parameter int unsigned ACCW  = acc_width(WIDTH),
   parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
   parameter int unsigned AW    = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*WIDTH-1:0] req_frame,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [ACCW-1:0]      cfg_wdata,
   output logic                 cfg_err,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [1:0]           res_class,
   output logic [ACCW-1:0]      res_sum,
   output logic [IDW-1:0]       res_id,
   output logic                 busy
);

   localparam int unsigned IXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t                 state, state_nxt;
   logic [IDW-1:0]         rr_ptr, gnt_idx, id_q;
   logic [NREQ-1:0]        gnt;
   logic [WIDTH-1:0]       frame_q, frame_sel;
   logic [ACCW-1:0]        acc, acc_nxt, th_cross, th_circle;
   logic [IXW-1:0]         idx;
   logic [WIDTH-1:0][1:0]  w;
   logic [1:0]             term, cls_q, cls_nxt;
   logic                   xfer, last, hs, cfg_ok, cfg_err_q;
   logic                   wr_en, pend_q;
   logic [AW-1:0]          wr_addr, pend_addr;
   logic [ACCW-1:0]        wr_data, pend_data;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IDW)
   ) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .en  ((state == S_IDLE) && rst_n),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   always_comb begin
      frame_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         if (gnt[i]) frame_sel = req_frame[i*WIDTH +: WIDTH];
   end

   assign term    = w[idx] & {2{frame_q[idx]}};
   assign acc_nxt = acc + ACCW'(term);
   assign last    = (idx == IXW'(WIDTH - 1));

   always_comb begin
      cls_nxt = CLS_NONE;
      if (acc_nxt == th_cross)       cls_nxt = CLS_CROSS;
      else if (acc_nxt == th_circle) cls_nxt = CLS_CIRCLE;
   end

   assign hs     = (state == S_RESULT) && res_ready;
   assign cfg_ok = cfg_we && (state == S_IDLE) && (cfg_addr <= AW'(WIDTH + 1));

   // A write landing with a grant is parked until the handshake so the
   // frame just granted still sees the old weights and thresholds.
   assign wr_en   = (cfg_ok && !xfer) || (hs && pend_q);
   assign wr_addr = hs ? pend_addr : cfg_addr;
   assign wr_data = hs ? pend_data : cfg_wdata;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (xfer)      state_nxt = S_RUN;
         S_RUN:    if (last)      state_nxt = S_RESULT;
         S_RESULT: if (res_ready) state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         id_q      <= '0;
         frame_q   <= '0;
         acc       <= '0;
         idx       <= '0;
         cls_q     <= CLS_NONE;
         cfg_err_q <= 1'b0;
         pend_q    <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         th_cross  <= ACCW'(DEF_TH_CROSS);
         th_circle <= ACCW'(DEF_TH_CIRCLE);
         for (int unsigned i = 0; i < WIDTH; i++) w[i] <= def_weight(i);
      end else begin
         cfg_err_q <= cfg_we && !cfg_ok;

         if ((state == S_IDLE) && xfer) begin
            frame_q <= frame_sel;
            id_q    <= gnt_idx;
            acc     <= '0;
            idx     <= '0;
            rr_ptr  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end

         if (state == S_RUN) begin
            acc <= acc_nxt;
            idx <= idx + 1'b1;
            if (last) cls_q <= cls_nxt;
         end

         if (cfg_ok && xfer) begin
            pend_q    <= 1'b1;
            pend_addr <= cfg_addr;
            pend_data <= cfg_wdata;
         end else if (hs) begin
            pend_q    <= 1'b0;
         end

         if (wr_en) begin
            for (int unsigned i = 0; i < WIDTH; i++)
               if (wr_addr == AW'(i)) w[i] <= wr_data[1:0];
            if (wr_addr == AW'(WIDTH))     th_cross  <= wr_data;
            if (wr_addr == AW'(WIDTH + 1)) th_circle <= wr_data;
         end
      end
   end

   assign res_valid = (state == S_RESULT);
   assign busy      = (state != S_IDLE);
   assign res_class = cls_q;
   assign res_sum   = acc;
   assign res_id    = id_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: doc/perceptron_sched.md
# perceptron_sched

Round-robin scheduler and configuration front-end for the bit-serial 5x5 perceptron classifier. It arbitrates frames from `NREQ` requesters and latches the granted frame. It then sequences one weight-times-pixel accumulation per cycle over `WIDTH` cycles and returns a tagged class result through a valid/ready handshake. It also owns the programmable weight and threshold registers that were previously fixed constants.

## Interface
Parameters:
- `WIDTH`, 25: pixels per frame.
- `NREQ`, 2: number of requesters.
- `ACCW`, `$clog2(3*WIDTH+1)`: accumulator and threshold width (7 at default).
- `IDW`, `max(1,$clog2(NREQ))`: requester tag width.
- `AW`, `$clog2(WIDTH+2)`: config address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NREQ`: per-requester frame valid.
- `req_frame`, in, `NREQ*WIDTH`: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`, out, `NREQ`: one-hot grant; the frame transfers on `req_valid[i] & req_ready[i]`.
- `cfg_we`, in, 1: config write strobe.
- `cfg_addr`, in, `AW`: addresses 0..`WIDTH-1` select a weight, `WIDTH` selects the cross threshold, `WIDTH+1` selects the circle threshold.
- `cfg_wdata`, in, `ACCW`: write data; weights use bits [1:0].
- `cfg_err`, out, 1: one-cycle pulse when a write is rejected.
- `res_valid`, out, 1: result valid.
- `res_ready`, in, 1: result accepted.
- `res_class`, out, 2: 2'b10 cross, 2'b01 circle, 2'b00 none.
- `res_sum`, out, `ACCW`: final accumulated sum.
- `res_id`, out, `IDW`: index of the requester that supplied the frame.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, RESULT.
- IDLE:
  - `req_ready` is asserted combinationally for the round-robin winner among the `req_valid` bits.
  - The round-robin search starts at `rr_ptr`.
  - On a transfer: latch the frame and requester id, clear `acc` and `idx`, set `rr_ptr` to (winner+1) mod `NREQ`, and go to RUN.
- RUN:
  - Each cycle: `acc <= acc + (w[idx] & {2{frame[idx]}})`, zero-extended to `ACCW`, then `idx <= idx+1`.
  - After the term at `idx == WIDTH-1`, go to RESULT.
  - Register the class from the final sum in the same cycle.
  - `req_ready` is all zeros in RUN.
- Class rule:
  - sum == cross threshold gives 2'b10.
  - Otherwise, sum == circle threshold gives 2'b01.
  - Otherwise 2'b00.
  - If both thresholds are equal, cross wins.
- RESULT:
  - `res_valid` is high.
  - `res_class`, `res_sum` and `res_id` hold stable until `res_valid & res_ready`.
  - On that handshake, go to IDLE.
- Requesters hold `req_valid` and `req_frame` stable until granted. A requester that drops valid before its grant is simply skipped.
- Configuration:
  - Writes are accepted only in IDLE.
  - `cfg_we` outside IDLE, or with `cfg_addr > WIDTH+1`, is ignored and pulses `cfg_err` on the next cycle.
  - A write and a grant in the same IDLE cycle are both accepted. The new value is visible only to frames granted later.
- Reset values:
  - Weights: w[12]=3; w[0], w[4], w[20], w[24]=2; all others 0.
  - Thresholds: cross 11, circle 4.
  - FSM in IDLE; `rr_ptr`, `acc`, `idx` are 0.
  - Outputs: `req_ready` 0 until the first cycle out of reset; `res_valid`, `res_class`, `res_sum`, `res_id`, `busy` and `cfg_err` are 0.
- Reset mid-RUN or mid-RESULT aborts the frame with no result. Weights and thresholds revert to their defaults.

## Timing
- Grant at edge E0. `res_valid` rises after edge E(WIDTH), i.e. `WIDTH` cycles after the grant.
- The earliest next grant is the cycle after the result handshake.
- With `res_ready` tied high, throughput is one frame per `WIDTH+2` cycles.
- `req_ready` depends only on state, `rr_ptr` and `req_valid`; it has no path from `res_ready`.
- `res_*` are driven directly from registers.

## Structure
- `perceptron_pkg` holds:
  - the state encoding;
  - default weight vector and default thresholds (11, 4);
  - class codes 2'b10 and 2'b01;
  - the `ACCW` derivation.
- Sub-module `rr_arbiter` (parameter `N`) takes `req`, `ptr` and `en` and returns a one-hot `gnt` plus the encoded index.
- Accumulator, FSM and config registers stay in `perceptron_sched`.

## Test plan
- **Cross frame after reset.** Req0 sends a frame with bits 0, 4, 12, 20, 24 set. Expect `res_valid` exactly 25 cycles after the grant, with `res_sum`=11, `res_class`=2'b10, `res_id`=0.
- **Circle frame.** Req1 sends a frame with bits 0 and 4 set. Expect sum 4 and class 2'b01. An all-zero frame gives sum 0 and class 2'b00.
- **Round-robin fairness.** Hold both `req_valid` high continuously. Expect grants 0, 1, 0, 1, with matching `res_id`s and never two grants in flight.
- **Backpressure.** Hold `res_ready` low for 10 cycles in RESULT. Expect `res_*` stable, `req_ready` all zeros and `busy`=1, then a return to IDLE on the handshake.
- **Configuration.**
  - In IDLE, write w[2]=1 and circle threshold=1. A frame with bit 2 set then gives class 2'b01.
  - A write during RUN is ignored and pulses `cfg_err`.
  - A write to address 27 is ignored and pulses `cfg_err`.
- **Reset mid-RUN.** Assert `rst_n` low at `idx`=10. Expect all outputs 0 immediately, no result, and weights back to defaults. The first grant after reset goes to requester 0.
